// File: rtl/pwm_duty_decoder.sv
// Recovers the duty value of a free-running PWM waveform with period 2^W clocks.
// A value is reported only after MATCH_N consecutive windows measure the same high count.
module pwm_duty_decoder #(
  parameter int unsigned W           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MATCH_N     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  output logic [W:0]   duty,
  output logic         locked,
  output logic         upd
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [3:0] MatchN = 4'(MATCH_N);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [W-1:0]           r_win_cnt;
  logic [W:0]             r_hcnt;
  logic [W:0]             r_cand;
  logic [2:0]             r_match_cnt;
  logic [1:0]             r_state;
  logic [W:0]             r_duty;
  logic                   r_locked;
  logic                   r_upd;

  logic                   w_pwm_s;
  logic                   w_eow;
  logic [W:0]             w_meas;
  logic [3:0]             w_match_inc;
  logic [1:0]             w_state_d;
  logic [W:0]             w_cand_d;
  logic [2:0]             w_match_d;
  logic [W:0]             w_duty_d;
  logic                   w_upd_d;

  assign w_pwm_s     = r_sync[SYNC_STAGES-1];
  assign w_eow       = (r_win_cnt == '1);
  // The sample taken on the EOW cycle still belongs to the closing window.
  assign w_meas      = r_hcnt + {{W{1'b0}}, w_pwm_s};
  assign w_match_inc = {1'b0, r_match_cnt} + 4'd1;

  always_comb begin
    w_state_d = r_state;
    w_cand_d  = r_cand;
    w_match_d = r_match_cnt;
    w_duty_d  = r_duty;
    w_upd_d   = 1'b0;
    if (w_eow) begin
      case (r_state)
        SEARCH: begin
          w_cand_d  = w_meas;
          w_match_d = 3'd1;
          if (MATCH_N == 1) begin
            w_state_d = LOCKED;
            w_duty_d  = w_meas;
            w_upd_d   = (w_meas != r_duty);
          end else begin
            w_state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (w_meas == r_cand) begin
            w_match_d = w_match_inc[2:0];
            if (w_match_inc >= MatchN) begin
              w_state_d = LOCKED;
              w_duty_d  = r_cand;
              w_upd_d   = (r_cand != r_duty);
            end
          end else begin
            w_cand_d  = w_meas;
            w_match_d = 3'd1;
          end
        end
        LOCKED: begin
          // duty keeps its old value until a new value is confirmed.
          if (w_meas != r_duty) begin
            w_cand_d  = w_meas;
            w_match_d = 3'd1;
            w_state_d = CONFIRM;
          end
        end
        default: w_state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= '0;
      r_win_cnt   <= '0;
      r_hcnt      <= '0;
      r_cand      <= '0;
      r_match_cnt <= '0;
      r_state     <= SEARCH;
      r_duty      <= '0;
      r_locked    <= 1'b0;
      r_upd       <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_win_cnt   <= r_win_cnt + 1'b1;
      r_hcnt      <= w_eow ? '0 : w_meas;
      r_cand      <= w_cand_d;
      r_match_cnt <= w_match_d;
      r_state     <= w_state_d;
      r_duty      <= w_duty_d;
      r_locked    <= (w_state_d == LOCKED);
      r_upd       <= w_upd_d;
    end
  end

  assign duty   = r_duty;
  assign locked = r_locked;
  assign upd    = r_upd;

endmodule
